// File: rtl/pipe_exe_muldiv_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit (pipe_exe_muldiv).
// Helpers are sized for DEF_WIDTH, the width the unit is built at.
package pipe_muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DBL_W     = 2 * DEF_WIDTH;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Two's-complement negate of a double-width value when en is set.
   function automatic logic [DBL_W-1:0] negate(input logic [DBL_W-1:0] v, input logic en);
      return en ? (~v + DBL_W'(1)) : v;
   endfunction

   // Negate the upper and lower halves independently (abs of operand pair, div sign fix).
   function automatic logic [DBL_W-1:0] negate_halves(input logic [DBL_W-1:0] v,
                                                      input logic en_hi, input logic en_lo);
      logic [DEF_WIDTH-1:0] h;
      logic [DEF_WIDTH-1:0] l;
      h = v[DBL_W-1:DEF_WIDTH];
      l = v[DEF_WIDTH-1:0];
      if (en_hi) h = ~h + DEF_WIDTH'(1);
      if (en_lo) l = ~l + DEF_WIDTH'(1);
      return {h, l};
   endfunction

endpackage

// File: rtl/pipe_exe_muldiv_if.sv
// Pipeline-side port bundle of the EX mul/div unit; clock and reset stay scalar at the top.
interface pipe_exe_muldiv_if
   import pipe_muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   // Handshake: start/mthi/mtlo/mfhi/mflo are requests of the EX instruction in the current
   // cycle. A request takes effect at the rising edge only if stall is low in that cycle;
   // while stall is high the front end holds the request unchanged and re-presents it.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] ea;
   logic [WIDTH-1:0] eb;
   logic             mthi;
   logic             mtlo;
   logic             mfhi;
   logic             mflo;
   logic             stall;
   logic             busy;
   logic [WIDTH-1:0] hilo_out;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, ea, eb, mthi, mtlo, mfhi, mflo,
      input  stall, busy, hilo_out, hi, lo
   );

   modport slave (
      input  start, op, ea, eb, mthi, mtlo, mfhi, mflo,
      output stall, busy, hilo_out, hi, lo
   );

endinterface

// File: rtl/pipe_exe_muldiv_div_step.sv
// One combinational restoring-divide step: shift in the next dividend bit, subtract if it fits.
module pipe_div_step
   import pipe_muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // The partial remainder is always below the divisor, so WIDTH+1 bits hold the shift.
   assign shifted = {rem_in, quo_in[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};
   assign fits    = ~diff[WIDTH];
   assign rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/pipe_exe_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and front-end stall.
// Build option MULDIV_FAST_MUL_EN: multiplies finish in one cycle through a combinational multiplier.
module pipe_exe_muldiv
   import pipe_muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   pipe_exe_muldiv_if.slave bus,
   output state_t           dbg_state
);
   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [2*WIDTH-1:0] acc_q, acc_n;
   logic [WIDTH-1:0]   opd_q, opd_n;
   logic [WIDTH-1:0]   hi_q, hi_n;
   logic [WIDTH-1:0]   lo_q, lo_n;
   logic               is_div_q, is_div_n;
   logic               qneg_q, qneg_n;
   logic               rneg_q, rneg_n;

   logic               busy;
   logic               op_signed, op_div, sa, sb, fast_mul;
   logic [2*WIDTH-1:0] abs_ab;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH-1:0]   rem_step, quo_step;
   logic [WIDTH:0]     add_sum;

   assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign sa        = op_signed & bus.ea[WIDTH-1];
   assign sb        = op_signed & bus.eb[WIDTH-1];
   assign abs_ab    = negate_halves({bus.ea, bus.eb}, sa, sb);
   assign abs_a     = abs_ab[2*WIDTH-1:WIDTH];
   assign abs_b     = abs_ab[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = negate({{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b}, sa ^ sb);
   assign fast_mul  = ~op_div;
`else
   assign fast_mul  = 1'b0;
`endif

   // Shift-add: acc = {partial product, remaining multiplier bits}; opd holds the multiplicand.
   assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

   // Divide reuses acc as {remainder, quotient/dividend} and opd as the divisor.
   pipe_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
      .quo_in  (acc_q[WIDTH-1:0]),
      .dvs     (opd_q),
      .rem_out (rem_step),
      .quo_out (quo_step)
   );

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      acc_n    = acc_q;
      opd_n    = opd_q;
      hi_n     = hi_q;
      lo_n     = lo_q;
      is_div_n = is_div_q;
      qneg_n   = qneg_q;
      rneg_n   = rneg_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (fast_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                  {hi_n, lo_n} = fast_prod;
`endif
               end else begin
                  state_n  = ST_RUN;
                  cnt_n    = CNT_W'(WIDTH - 1);
                  is_div_n = op_div;
                  qneg_n   = sa ^ sb;
                  rneg_n   = sa;
                  opd_n    = op_div ? abs_b : abs_a;
                  acc_n    = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
               end
            end else begin
               // mt* only reach here unstalled; start wins when both are set.
               if (bus.mthi) hi_n = bus.ea;
               if (bus.mtlo) lo_n = bus.ea;
            end
         end
         ST_RUN: begin
            acc_n = is_div_q ? {rem_step, quo_step} : {add_sum, acc_q[WIDTH-1:1]};
            if (cnt_q == '0) state_n = ST_FIX;
            else             cnt_n   = cnt_q - CNT_W'(1);
         end
         ST_FIX: begin
            if (is_div_q) {hi_n, lo_n} = negate_halves(acc_q, rneg_q, qneg_q);
            else          {hi_n, lo_n} = negate(acc_q, qneg_q);
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         acc_q    <= acc_n;
         opd_q    <= opd_n;
         hi_q     <= hi_n;
         lo_q     <= lo_n;
         is_div_q <= is_div_n;
         qneg_q   <= qneg_n;
         rneg_q   <= rneg_n;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign bus.busy     = busy;
   assign bus.stall    = busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
   assign bus.hilo_out = bus.mfhi ? hi_q : lo_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Directed bench for pipe_exe_muldiv: completions are checked against an expected queue of {hi,lo}.
module tb_pipe_exe_muldiv;
   import pipe_muldiv_pkg::*;

   localparam int W  = 32;
   localparam int QW = 2 * W;

   logic   clock;
   logic   reset;
   state_t dbg_state;

   pipe_exe_muldiv_if #(.WIDTH(W)) bus ();

   pipe_exe_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int              checks = 0;
   int              errors = 0;
   logic [QW-1:0]   exp_q[$];
   string           name_q[$];
   logic            busy_prev;

   task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: a completed op is signalled by busy falling outside reset.
   always @(negedge clock) begin
      if (reset) begin
         busy_prev = 1'b0;
      end else begin
         if (busy_prev && !bus.busy) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion: got hi=%h lo=%h, expected no completion",
                        bus.hi, bus.lo);
            end else begin
               logic [QW-1:0] e;
               string         n;
               e = exp_q.pop_front();
               n = name_q.pop_front();
               check(n, {bus.hi, bus.lo}, e);
            end
         end
         busy_prev = bus.busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clock); #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.ea    = a;
      bus.eb    = b;
      @(negedge clock);
      check("start_idle_no_stall", bus.stall, 0);
      @(posedge clock); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int bc);
      bit done;
      bc   = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (bus.busy) bc++;
         else          done = 1'b1;
      end
      check({name, "_done_in_time"}, done, 1);
   endtask

   task automatic wait_unstall(input string name, output int sc);
      bit done;
      sc   = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (bus.stall) sc++;
         else           done = 1'b1;
      end
      check({name, "_unstall_in_time"}, done, 1);
   endtask

   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int bc;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) begin
         issue(op, a, b);
         check({name, "_fast_busy"}, bus.busy, 0);
         check({name, "_fast"}, {bus.hi, bus.lo}, {ehi, elo});
         return;
      end
`endif
      exp_q.push_back({ehi, elo});
      name_q.push_back(name);
      issue(op, a, b);
      wait_done(name, bc);
      check({name, "_busy_cycles"}, bc, W + 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.ea    = '0;
      bus.eb    = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      bus.mfhi  = 1'b0;
      bus.mflo  = 1'b0;
      reset     = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", bus.busy, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_hilo", {bus.hi, bus.lo}, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(posedge clock); #1;
      reset = 1'b0;

      // mthi / mtlo / mfhi in IDLE
      bus.mthi = 1'b1;
      bus.ea   = 32'h0000_1234;
      @(negedge clock);
      check("mthi_no_stall", bus.stall, 0);
      @(posedge clock); #1;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b1;
      bus.ea   = 32'h0000_5678;
      @(negedge clock);
      check("mthi_hi", bus.hi, 32'h0000_1234);
      @(posedge clock); #1;
      bus.mtlo = 1'b0;
      bus.mfhi = 1'b1;
      @(negedge clock);
      check("mtlo_lo", bus.lo, 32'h0000_5678);
      check("mfhi_out", bus.hilo_out, 32'h0000_1234);
      @(posedge clock); #1;
      bus.mfhi = 1'b0;
      bus.mflo = 1'b1;
      @(negedge clock);
      check("mflo_out", bus.hilo_out, 32'h0000_5678);
      @(posedge clock); #1;
      bus.mflo = 1'b0;

      // directed arithmetic vectors
      run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_6x7",     OP_MULT,  32'd6,         32'd7,         32'h0000_0000, 32'd42);
      run_op("mult_min_sq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("multu_shift",  OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
      run_op("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_neg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("div_min_neg1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_5_0",     OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
      run_op("div_neg9_0",   OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'h0000_0001);
      run_op("div_9_0",      OP_DIV,   32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF);
      run_op("divu_big",     OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

      // mflo three cycles after a DIVU start stalls until the cycle after FIX
      exp_q.push_back({32'd2, 32'd14});
      name_q.push_back("divu_100_7");
      issue(OP_DIVU, 32'd100, 32'd7);
      @(posedge clock); #1;
      @(posedge clock); #1;
      bus.mflo = 1'b1;
      wait_unstall("mflo", n);
      check("mflo_stall_cycles", n, W - 1);
      check("mflo_after_fix", bus.hilo_out, 32'd14);
      @(posedge clock); #1;
      bus.mflo = 1'b0;
      bus.mfhi = 1'b1;
      @(negedge clock);
      check("mfhi_after_fix_stall", bus.stall, 0);
      check("mfhi_after_fix", bus.hilo_out, 32'd2);
      @(posedge clock); #1;
      bus.mfhi = 1'b0;

      // mthi held across a busy divide writes only once the stall drops
      exp_q.push_back({32'd2, 32'd16});
      name_q.push_back("divu_50_3");
      issue(OP_DIVU, 32'd50, 32'd3);
      @(posedge clock); #1;
      bus.mthi = 1'b1;
      bus.ea   = 32'h0000_ABCD;
      wait_unstall("mthi_busy", n);
      check("mthi_busy_stall_cycles", n, W);
      @(posedge clock); #1;
      bus.mthi = 1'b0;
      @(negedge clock);
      check("mthi_after_stall_hi", bus.hi, 32'h0000_ABCD);
      check("mthi_after_stall_lo", bus.lo, 32'd16);

      // start presented while busy is held off, then accepted
      exp_q.push_back({32'd2, 32'd3});
      name_q.push_back("divu_20_6");
      exp_q.push_back({32'd1, 32'd2});
      name_q.push_back("divu_9_4_held");
      issue(OP_DIVU, 32'd20, 32'd6);
      @(posedge clock); #1;
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.ea    = 32'd9;
      bus.eb    = 32'd4;
      wait_unstall("start_busy", n);
      check("start_busy_stall_cycles", n, W);
      @(posedge clock); #1;
      bus.start = 1'b0;
      wait_done("divu_9_4_held", n);
      check("divu_9_4_held_busy_cycles", n, W + 1);

      // reset in RUN cycle 10 aborts the op and clears HI/LO
`ifdef MULDIV_FAST_MUL_EN
      issue(OP_DIVU, 32'd77, 32'd5);
`else
      issue(OP_MULT, 32'd5, 32'd5);
`endif
      repeat (9) @(posedge clock);
      @(negedge clock);
      check("abort_in_run", dbg_state, ST_RUN);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("abort_busy", bus.busy, 0);
      check("abort_stall", bus.stall, 0);
      check("abort_hilo", {bus.hi, bus.lo}, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("abort_stays_idle", dbg_state, ST_IDLE);

      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
